// File: rtl/selftrigger_sequencer_arbiter.sv
// selftrigger_sequencer_arbiter: clear/settle/run sequencer for shared-threshold self-trigger filters,
// with per-channel edge capture, deadtime and a round-robin valid/ready event readout.
module selftrigger_sequencer_arbiter #(
    parameter int NCH           = 4,
    parameter int CHW           = 2,
    parameter int CLEAR_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 256,
    parameter int DEADTIME      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_cfg_start,
    input  logic [31:0]           i_cfg_threshold,
    output logic                  o_filt_clear,
    output logic                  o_filt_enable,
    output logic [31:0]           o_threshold_out,
    input  logic [NCH-1:0]        i_trig_in,
    output logic                  o_trig_valid,
    input  logic                  i_trig_ready,
    output logic [CHW-1:0]        o_trig_chan,
    output logic [31:0]           o_trig_ts,
    output logic [15:0]           o_trig_dropped,
    output logic [1:0]            o_state
);
    typedef enum logic [1:0] {IDLE, CLEAR, SETTLE, RUN} state_t;
    localparam int DTW = $clog2(DEADTIME + 1);
    localparam int NDW = $clog2(NCH + 1);

    state_t         r_state;
    logic [31:0]    r_cnt;
    logic [31:0]    r_ts;
    logic [NCH-1:0] r_trig_q;
    logic [NCH-1:0] r_pending;
    logic [DTW-1:0] r_dt [NCH];
    logic [31:0]    r_ts_pend [NCH];
    logic [CHW-1:0] r_last;

    logic [NCH-1:0] w_edge, w_dt_zero, w_hs_clr, w_acc, w_drop, w_avail;
    logic           w_hs, w_free, w_found;
    logic [CHW-1:0] w_sel;
    logic [NDW-1:0] w_ndrop;
    logic [16:0]    w_drop_sum;

    assign o_state    = r_state;
    assign w_hs       = o_trig_valid & i_trig_ready;
    assign w_free     = ~o_trig_valid | i_trig_ready;
    assign w_hs_clr   = w_hs ? (NCH'(1) << o_trig_chan) : '0;
    assign w_edge     = (r_state == RUN) ? (i_trig_in & ~r_trig_q) : '0;
    // A channel being handed off this cycle can take a fresh edge as a new event
    assign w_acc      = w_edge & w_dt_zero & (~r_pending | w_hs_clr);
    assign w_drop     = w_edge & w_dt_zero & r_pending & ~w_hs_clr;
    assign w_avail    = r_pending & ~w_hs_clr;
    assign w_drop_sum = {1'b0, o_trig_dropped} + 17'(w_ndrop);

    genvar g;
    for (g = 0; g < NCH; g++) begin : g_dt
        assign w_dt_zero[g] = (r_dt[g] == '0);
    end

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < NCH; i++) w_ndrop = w_ndrop + NDW'(w_drop[i]);
    end

    // Round-robin search starting one past the last granted channel
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!w_found && w_avail[(int'(r_last) + k) % NCH]) begin
                w_found = 1'b1;
                w_sel   = CHW'((int'(r_last) + k) % NCH);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_ts            <= '0;
            r_trig_q        <= '0;
            r_pending       <= '0;
            r_last          <= CHW'(NCH - 1);
            o_filt_clear    <= 1'b1;
            o_filt_enable   <= 1'b0;
            o_threshold_out <= '0;
            o_trig_valid    <= 1'b0;
            o_trig_chan     <= '0;
            o_trig_ts       <= '0;
            o_trig_dropped  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_dt[i]      <= '0;
                r_ts_pend[i] <= '0;
            end
        end else begin
            r_trig_q  <= i_trig_in;
            r_pending <= w_acc | (r_pending & ~w_hs_clr);
            for (int i = 0; i < NCH; i++) begin
                if (w_edge[i] && w_dt_zero[i]) r_dt[i] <= DTW'(DEADTIME);
                else if (!w_dt_zero[i])        r_dt[i] <= r_dt[i] - DTW'(1);
                if (w_acc[i]) r_ts_pend[i] <= r_ts;
            end
            o_trig_dropped <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_free) begin
                o_trig_valid <= w_found;
                if (w_found) begin
                    o_trig_chan <= w_sel;
                    o_trig_ts   <= r_ts_pend[w_sel];
                    r_last      <= w_sel;
                end
            end
            case (r_state)
                IDLE: begin
                    o_filt_clear  <= 1'b1;
                    o_filt_enable <= 1'b0;
                end
                CLEAR: begin
                    if (r_cnt == 32'd0) begin
                        r_state       <= SETTLE;
                        r_cnt         <= 32'(SETTLE_CYCLES - 1);
                        o_filt_clear  <= 1'b0;
                        o_filt_enable <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == 32'd0) begin
                        r_state <= RUN;
                        r_ts    <= '0;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                RUN: r_ts <= r_ts + 32'd1;
                default: r_state <= IDLE;
            endcase
            // Restart wins over everything above, including a held event
            if (i_cfg_start) begin
                r_state         <= CLEAR;
                r_cnt           <= 32'(CLEAR_CYCLES - 1);
                o_threshold_out <= i_cfg_threshold;
                o_filt_clear    <= 1'b1;
                o_filt_enable   <= 1'b0;
                r_pending       <= '0;
                o_trig_valid    <= 1'b0;
                o_trig_dropped  <= '0;
                for (int i = 0; i < NCH; i++) r_dt[i] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_selftrigger_sequencer_arbiter.sv
// tb_selftrigger_sequencer_arbiter: directed scenario tasks for the self-trigger sequencer/arbiter.
`timescale 1ns/1ps
module tb_selftrigger_sequencer_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_threshold = '0;
    logic [3:0]  trig_in = '0;
    logic        trig_ready = 1'b0;
    logic        filt_clear, filt_enable, trig_valid;
    logic [31:0] threshold_out, trig_ts;
    logic [1:0]  trig_chan, state;
    logic [15:0] trig_dropped;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_base = 0;
    localparam logic [86:0] RESET_VEC = {2'd0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 16'd0};

    selftrigger_sequencer_arbiter dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_cfg_start(cfg_start), .i_cfg_threshold(cfg_threshold),
        .o_filt_clear(filt_clear), .o_filt_enable(filt_enable), .o_threshold_out(threshold_out),
        .i_trig_in(trig_in), .o_trig_valid(trig_valid), .i_trig_ready(trig_ready),
        .o_trig_chan(trig_chan), .o_trig_ts(trig_ts), .o_trig_dropped(trig_dropped), .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [86:0] outs();
        return {state, filt_clear, filt_enable, threshold_out, trig_valid, trig_chan, trig_ts, trig_dropped};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values got %h expected %h", outs(), RESET_VEC);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (state !== 2'd0 || filt_clear !== 1'b1) begin
            errors++;
            $display("FAIL idle got state=%0d clear=%0d expected state=0 clear=1", state, filt_clear);
        end
    endtask

    task automatic test_init();
        int n;
        int bad;
        cfg_threshold = 32'(-45);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        checks++;
        if (threshold_out !== 32'hFFFF_FFD3) begin
            errors++;
            $display("FAIL threshold got %h expected ffffffd3", threshold_out);
        end
        n = 0;
        bad = 0;
        while (state == 2'd1 && n < 20) begin
            if (!filt_clear || filt_enable) bad++;
            n++;
            tick();
        end
        checks++;
        if (n != 4 || bad != 0) begin
            errors++;
            $display("FAIL clear_len got %0d cycles (%0d bad) expected 4 (0 bad)", n, bad);
        end
        n = 0;
        bad = 0;
        while (state == 2'd2 && n < 400) begin
            if (filt_clear || !filt_enable) bad++;
            n++;
            tick();
        end
        checks++;
        if (n != 256 || bad != 0) begin
            errors++;
            $display("FAIL settle_len got %0d cycles (%0d bad) expected 256 (0 bad)", n, bad);
        end
        checks++;
        if (state !== 2'd3 || filt_enable !== 1'b1 || filt_clear !== 1'b0) begin
            errors++;
            $display("FAIL run_entry got state=%0d en=%0d clr=%0d expected 3 1 0", state, filt_enable, filt_clear);
        end
        run_base = cyc;
    endtask

    task automatic test_single();
        int n;
        trig_ready = 1'b1;
        while (cyc - run_base < 10) tick();
        trig_in[2] = 1'b1;
        tick();
        checks++;
        if (trig_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency got valid=%0d expected 0", trig_valid);
        end
        tick();
        checks++;
        if ({trig_valid, trig_chan, trig_ts} !== {1'b1, 2'd2, 32'd10}) begin
            errors++;
            $display("FAIL single_event got v=%0d ch=%0d ts=%0d expected 1 2 10", trig_valid, trig_chan, trig_ts);
        end
        tick();
        checks++;
        if (trig_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_handshake got valid=%0d expected 0", trig_valid);
        end
        trig_in[2] = 1'b0;
        repeat (5) tick();
        trig_in[2] = 1'b1;
        n = 0;
        repeat (20) begin
            tick();
            if (trig_valid) n++;
        end
        checks++;
        if (n != 0 || trig_dropped !== 16'd0) begin
            errors++;
            $display("FAIL deadtime_ignore got %0d valid cycles dropped=%0d expected 0 0", n, trig_dropped);
        end
        trig_in[2] = 1'b0;
        repeat (70) tick();
    endtask

    task automatic test_ch3();
        int t;
        t = cyc - run_base;
        trig_in[3] = 1'b1;
        tick();
        trig_in[3] = 1'b0;
        tick();
        checks++;
        if ({trig_valid, trig_chan, trig_ts} !== {1'b1, 2'd3, 32'(t)}) begin
            errors++;
            $display("FAIL ch3_event got v=%0d ch=%0d ts=%0d expected 1 3 %0d", trig_valid, trig_chan, trig_ts, t);
        end
        repeat (70) tick();
    endtask

    task automatic test_back_to_back(input logic rdy);
        int t;
        t = cyc - run_base;
        trig_ready = rdy;
        trig_in = 4'hF;
        tick();
        trig_in = 4'h0;
        tick();
        if (!rdy) repeat (3) tick();
        checks++;
        if ({trig_valid, trig_chan, trig_ts} !== {1'b1, 2'd0, 32'(t)}) begin
            errors++;
            $display("FAIL burst_first got v=%0d ch=%0d ts=%0d expected 1 0 %0d", trig_valid, trig_chan, trig_ts, t);
        end
        trig_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++;
            if ({trig_valid, trig_chan, trig_ts} !== {1'b1, 2'(k), 32'(t)}) begin
                errors++;
                $display("FAIL burst_order got v=%0d ch=%0d ts=%0d expected 1 %0d %0d", trig_valid, trig_chan, trig_ts, k, t);
            end
        end
        tick();
        checks++;
        if (trig_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_end got valid=%0d expected 0", trig_valid);
        end
        repeat (70) tick();
    endtask

    task automatic test_drop();
        int t;
        trig_ready = 1'b0;
        t = cyc - run_base;
        trig_in[1] = 1'b1;
        tick();
        trig_in[1] = 1'b0;
        tick();
        checks++;
        if ({trig_valid, trig_chan, trig_ts} !== {1'b1, 2'd1, 32'(t)}) begin
            errors++;
            $display("FAIL drop_first got v=%0d ch=%0d ts=%0d expected 1 1 %0d", trig_valid, trig_chan, trig_ts, t);
        end
        repeat (68) tick();
        trig_in[1] = 1'b1;
        tick();
        trig_in[1] = 1'b0;
        tick();
        checks++;
        if ({trig_dropped, trig_valid, trig_chan, trig_ts} !== {16'd1, 1'b1, 2'd1, 32'(t)}) begin
            errors++;
            $display("FAIL drop_count got drop=%0d v=%0d ch=%0d ts=%0d expected 1 1 1 %0d",
                     trig_dropped, trig_valid, trig_chan, trig_ts, t);
        end
    endtask

    task automatic test_cfg_during_valid();
        int n;
        cfg_threshold = 32'd1234;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        checks++;
        if ({trig_valid, state, trig_dropped, threshold_out} !== {1'b0, 2'd1, 16'd0, 32'd1234}) begin
            errors++;
            $display("FAIL cfg_abort got v=%0d st=%0d drop=%0d thr=%0d expected 0 1 0 1234",
                     trig_valid, state, trig_dropped, threshold_out);
        end
        trig_ready = 1'b1;
        n = 0;
        repeat (8) begin
            tick();
            if (trig_valid) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL cfg_no_emit got %0d valid cycles expected 0", n);
        end
    endtask

    task automatic test_held_and_reset();
        int n;
        trig_in[0] = 1'b1;
        n = 0;
        while (state != 2'd3 && n < 400) begin
            n++;
            tick();
        end
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL held_run got state=%0d expected 3", state);
        end
        n = 0;
        repeat (20) begin
            tick();
            if (trig_valid) n++;
        end
        checks++;
        if (n != 0 || trig_dropped !== 16'd0) begin
            errors++;
            $display("FAIL held_no_event got %0d valid cycles dropped=%0d expected 0 0", n, trig_dropped);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (outs() !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset got %h expected %h", outs(), RESET_VEC);
        end
        trig_in = '0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_ch3();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_drop();
        test_cfg_during_valid();
        test_held_and_reset();
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
